// File: rtl/tour_pkg.sv
// Shared definitions for the knight's-tour monitor: move offsets, FSM states, error codes.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package tour_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    E_NONE       = 2'b00,
    E_OFFBOARD   = 2'b01,
    E_REVISIT    = 2'b10,
    E_UNDO_EMPTY = 2'b11
  } err_code_e;

  // Knight offsets by move index. Moves m and m^4 are exact opposites.
  localparam logic signed [2:0] MOVE_DX [8] = '{3'sd1, -3'sd1, -3'sd2, -3'sd2,
                                                -3'sd1, 3'sd1, 3'sd2, 3'sd2};
  localparam logic signed [2:0] MOVE_DY [8] = '{3'sd2, 3'sd2, 3'sd1, -3'sd1,
                                                -3'sd2, -3'sd2, -3'sd1, 3'sd1};

  function automatic logic [2:0] inv_move(input logic [2:0] m);
    return m ^ 3'd4;
  endfunction

endpackage

// File: rtl/tour_monitor_if.sv
// Command/status bundle between tour logic (master) and the tour monitor (slave).
// Latency: n/a; carries start/move/undo commands in and registered tour status out.
// Backpressure: move_vld/move_rdy handshake; start and undo are single-cycle pulses.
interface tour_monitor_if #(
  parameter int BOARD_W = 5,
  parameter int BOARD_H = 5
);
  localparam int XW  = $clog2(BOARD_W);
  localparam int YW  = $clog2(BOARD_H);
  localparam int NSQ = BOARD_W * BOARD_H;
  localparam int CW  = $clog2(NSQ + 1);

  logic          start;
  logic [XW-1:0] start_x;
  logic [YW-1:0] start_y;
  logic          move_vld;
  logic [2:0]    move;
  logic          move_rdy;
  logic          undo;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic [CW-1:0] visited_cnt;
  logic          done;
  logic          err;
  logic [1:0]    err_code;

  modport master (
    output start, start_x, start_y, move_vld, move, undo,
    input  move_rdy, cur_x, cur_y, visited_cnt, done, err, err_code
  );

  modport slave (
    input  start, start_x, start_y, move_vld, move, undo,
    output move_rdy, cur_x, cur_y, visited_cnt, done, err, err_code
  );
endinterface

// File: rtl/tour_stack.sv
// LIFO of accepted move indices, used to walk the knight back on undo.
// Latency: push/pop/clear take effect on the next edge; o_top/o_empty are read combinationally.
// Backpressure: none; pushes beyond DEPTH and pops when empty are dropped (callers never issue them).
// Ports: clk, rst (sync, high); i_push/i_pop/i_clear/i_dat in; o_empty/o_top out.
module tour_stack #(
  parameter int DEPTH = 24,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_top
);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    r_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    w_ptr_m1;
  logic             w_do_push;

  assign w_ptr_m1  = r_ptr - PW'(1);
  assign o_empty   = (r_ptr == '0);
  assign o_top     = r_mem[w_ptr_m1[AW-1:0]];
  assign w_do_push = i_push && !i_pop && !i_clear && (r_ptr != PW'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_ptr <= '0;
    end else if (i_pop && !o_empty) begin
      r_ptr <= w_ptr_m1;
    end else if (w_do_push) begin
      r_ptr <= r_ptr + PW'(1);
    end
  end

  // Storage needs no reset: entries above the pointer are never read.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_ptr[AW-1:0]] <= i_dat;
    end
  end
endmodule

// File: rtl/tour_monitor.sv
// Tracks a knight's tour (position, visited map, move stack) and flags illegal moves/undos.
// Latency: commands take effect on the next edge; all status registered, move_rdy combinational.
// Backpressure: move_rdy low outside TRACK or when start/undo is offered the same cycle.
// Ports: clk, rst (sync, high); bus = tour_monitor_if slave (commands in, status out).
module tour_monitor
  import tour_pkg::*;
#(
  parameter int BOARD_W = 5,
  parameter int BOARD_H = 5
) (
  input  logic          clk,
  input  logic          rst,
  tour_monitor_if.slave bus
);
  localparam int XW  = $clog2(BOARD_W);
  localparam int YW  = $clog2(BOARD_H);
  localparam int NSQ = BOARD_W * BOARD_H;
  localparam int CW  = $clog2(NSQ + 1);
  localparam int IW  = $clog2(NSQ);

  state_e        r_state, w_state_nxt;
  err_code_e     r_err, w_err_nxt;
  logic [XW-1:0] r_cur_x, w_cur_x_nxt;
  logic [YW-1:0] r_cur_y, w_cur_y_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [NSQ-1:0] r_board, w_board_nxt;

  logic              w_push, w_pop, w_clr, w_empty;
  logic [2:0]        w_top, w_inv;
  logic signed [2:0] w_mdx, w_mdy, w_udx, w_udy;
  logic signed [XW+1:0] w_tx;
  logic signed [YW+1:0] w_ty;
  logic [XW-1:0]     w_ux;
  logic [YW-1:0]     w_uy;
  logic              w_off, w_start_bad;
  logic [IW-1:0]     w_tgt_idx, w_cur_idx, w_start_idx;
  logic [CW-1:0]     w_cnt_inc;

  tour_stack #(.DEPTH(NSQ - 1), .WIDTH(3)) u_stack (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_clr),
    .i_dat   (bus.move),
    .o_empty (w_empty),
    .o_top   (w_top)
  );

  // Move target: two extra bits so a step left of column 0 shows as negative.
  always_comb begin
    w_mdx = MOVE_DX[bus.move];
    w_mdy = MOVE_DY[bus.move];
    w_tx  = $signed({2'b00, r_cur_x}) + $signed({{(XW-1){w_mdx[2]}}, w_mdx});
    w_ty  = $signed({2'b00, r_cur_y}) + $signed({{(YW-1){w_mdy[2]}}, w_mdy});
    w_off = w_tx[XW+1] || w_ty[YW+1] ||
            (w_tx[XW:0] >= (XW+1)'(BOARD_W)) || (w_ty[YW:0] >= (YW+1)'(BOARD_H));
    // Undo always lands on a square we came from, so modular XW-bit math suffices.
    w_inv = inv_move(w_top);
    w_udx = MOVE_DX[w_inv];
    w_udy = MOVE_DY[w_inv];
    w_ux  = r_cur_x + XW'(w_udx);
    w_uy  = r_cur_y + YW'(w_udy);
    w_tgt_idx   = IW'(w_ty[YW-1:0]) * IW'(BOARD_W) + IW'(w_tx[XW-1:0]);
    w_cur_idx   = IW'(r_cur_y) * IW'(BOARD_W) + IW'(r_cur_x);
    w_start_idx = IW'(bus.start_y) * IW'(BOARD_W) + IW'(bus.start_x);
    w_start_bad = ({1'b0, bus.start_x} >= (XW+1)'(BOARD_W)) ||
                  ({1'b0, bus.start_y} >= (YW+1)'(BOARD_H));
    w_cnt_inc   = r_cnt + CW'(1);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    w_cur_x_nxt = r_cur_x;
    w_cur_y_nxt = r_cur_y;
    w_cnt_nxt   = r_cnt;
    w_board_nxt = r_board;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_clr       = 1'b0;
    if (bus.start) begin
      w_clr = 1'b1;
      if (w_start_bad) begin
        w_state_nxt = S_ERR;
        w_err_nxt   = E_OFFBOARD;
      end else begin
        w_state_nxt = S_TRACK;
        w_err_nxt   = E_NONE;
        w_board_nxt = '0;
        w_board_nxt[w_start_idx] = 1'b1;
        w_cur_x_nxt = bus.start_x;
        w_cur_y_nxt = bus.start_y;
        w_cnt_nxt   = CW'(1);
      end
    end else begin
      case (r_state)
        S_TRACK, S_DONE: begin
          if (bus.undo) begin
            if (w_empty) begin
              w_state_nxt = S_ERR;
              w_err_nxt   = E_UNDO_EMPTY;
            end else begin
              w_pop       = 1'b1;
              w_board_nxt[w_cur_idx] = 1'b0;
              w_cur_x_nxt = w_ux;
              w_cur_y_nxt = w_uy;
              w_cnt_nxt   = r_cnt - CW'(1);
              w_state_nxt = S_TRACK;
            end
          end else if (r_state == S_TRACK && bus.move_vld) begin
            if (w_off) begin
              w_state_nxt = S_ERR;
              w_err_nxt   = E_OFFBOARD;
            end else if (r_board[w_tgt_idx]) begin
              w_state_nxt = S_ERR;
              w_err_nxt   = E_REVISIT;
            end else begin
              w_push      = 1'b1;
              w_board_nxt[w_tgt_idx] = 1'b1;
              w_cur_x_nxt = w_tx[XW-1:0];
              w_cur_y_nxt = w_ty[YW-1:0];
              w_cnt_nxt   = w_cnt_inc;
              if (w_cnt_inc == CW'(NSQ)) w_state_nxt = S_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_err   <= E_NONE;
      r_cur_x <= '0;
      r_cur_y <= '0;
      r_cnt   <= '0;
      r_board <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      r_cur_x <= w_cur_x_nxt;
      r_cur_y <= w_cur_y_nxt;
      r_cnt   <= w_cnt_nxt;
      r_board <= w_board_nxt;
    end
  end

  assign bus.move_rdy    = (r_state == S_TRACK) && !bus.undo && !bus.start;
  assign bus.cur_x       = r_cur_x;
  assign bus.cur_y       = r_cur_y;
  assign bus.visited_cnt = r_cnt;
  assign bus.done        = (r_state == S_DONE);
  assign bus.err         = (r_state == S_ERR);
  assign bus.err_code    = r_err;
endmodule

// File: tb/tb_tour_monitor.sv
// Scoreboard bench for tour_monitor on a 5x5 board (A) and a 6x4 board (B).
// Each cycle the driver pushes the expected response; a monitor pops and compares.
// Directed cases first, then mixed random traffic on both boards.
module tb_tour_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  tour_monitor_if #(.BOARD_W(5), .BOARD_H(5)) ifa ();
  tour_monitor_if #(.BOARD_W(6), .BOARD_H(4)) ifb ();

  tour_monitor #(.BOARD_W(5), .BOARD_H(5)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  tour_monitor #(.BOARD_W(6), .BOARD_H(4)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  localparam int DX [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  localparam int DY [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
  localparam int BW [2] = '{5, 6};
  localparam int BH [2] = '{5, 4};
  localparam int XM [2] = '{7, 7};
  localparam int YM [2] = '{7, 3};

  typedef struct {
    bit rst; bit start; int sx; int sy; bit vld; int mv; bit undo;
  } stim_t;

  typedef struct packed {
    logic       rdy;
    logic [7:0] x, y, cnt;
    logic       done, err;
    logic [1:0] code;
  } exp_t;

  exp_t qa[$], qb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: coordinates, a visited table and a move history per board.
  int m_x[2], m_y[2], m_cnt[2], m_code[2], m_sp[2];
  bit m_started[2], m_err[2];
  bit m_vis[2][64];
  int m_stk[2][64];

  int tour[24];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input int b, input int m);
    int tx, ty;
    tx = m_x[b] + DX[m];
    ty = m_y[b] + DY[m];
    if (tx < 0 || ty < 0 || tx >= BW[b] || ty >= BH[b]) return 1'b0;
    return !m_vis[b][ty * BW[b] + tx];
  endfunction

  task automatic model_step(input int b, input stim_t s, output exp_t e);
    int sx, sy, tx, ty, nsq, m;
    nsq = BW[b] * BH[b];
    sx  = s.sx & XM[b];
    sy  = s.sy & YM[b];
    e.rdy = m_started[b] && !m_err[b] && (m_cnt[b] != nsq) && !s.undo && !s.start;
    if (s.rst) begin
      m_started[b] = 1'b0; m_err[b] = 1'b0; m_code[b] = 0;
      m_x[b] = 0; m_y[b] = 0; m_cnt[b] = 0; m_sp[b] = 0;
      for (int i = 0; i < 64; i++) m_vis[b][i] = 1'b0;
    end else if (s.start) begin
      m_sp[b] = 0;
      if (sx >= BW[b] || sy >= BH[b]) begin
        m_err[b] = 1'b1; m_code[b] = 1;
      end else begin
        for (int i = 0; i < 64; i++) m_vis[b][i] = 1'b0;
        m_vis[b][sy * BW[b] + sx] = 1'b1;
        m_x[b] = sx; m_y[b] = sy; m_cnt[b] = 1;
        m_started[b] = 1'b1; m_err[b] = 1'b0; m_code[b] = 0;
      end
    end else if (m_started[b] && !m_err[b]) begin
      if (s.undo) begin
        if (m_sp[b] == 0) begin
          m_err[b] = 1'b1; m_code[b] = 3;
        end else begin
          m_sp[b]--;
          m = m_stk[b][m_sp[b]];
          m_vis[b][m_y[b] * BW[b] + m_x[b]] = 1'b0;
          m_x[b] -= DX[m]; m_y[b] -= DY[m];
          m_cnt[b]--;
        end
      end else if (s.vld && m_cnt[b] != nsq) begin
        tx = m_x[b] + DX[s.mv];
        ty = m_y[b] + DY[s.mv];
        if (tx < 0 || ty < 0 || tx >= BW[b] || ty >= BH[b]) begin
          m_err[b] = 1'b1; m_code[b] = 1;
        end else if (m_vis[b][ty * BW[b] + tx]) begin
          m_err[b] = 1'b1; m_code[b] = 2;
        end else begin
          m_vis[b][ty * BW[b] + tx] = 1'b1;
          m_x[b] = tx; m_y[b] = ty; m_cnt[b]++;
          m_stk[b][m_sp[b]] = s.mv; m_sp[b]++;
        end
      end
    end
    e.x    = 8'(m_x[b]);
    e.y    = 8'(m_y[b]);
    e.cnt  = 8'(m_cnt[b]);
    e.done = m_started[b] && !m_err[b] && (m_cnt[b] == nsq);
    e.err  = m_err[b];
    e.code = 2'(m_code[b]);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.start = 0; s.sx = 0; s.sy = 0; s.vld = 0; s.mv = 0; s.undo = 0;
    return s;
  endfunction
  function automatic stim_t mk_rst();
    stim_t s = idle(); s.rst = 1; return s;
  endfunction
  function automatic stim_t mk_start(input int x, input int y);
    stim_t s = idle(); s.start = 1; s.sx = x; s.sy = y; return s;
  endfunction
  function automatic stim_t mk_move(input int m);
    stim_t s = idle(); s.vld = 1; s.mv = m; return s;
  endfunction
  function automatic stim_t mk_undo();
    stim_t s = idle(); s.undo = 1; return s;
  endfunction

  function automatic stim_t rand_stim(input int b);
    stim_t s = idle();
    int r, n;
    int cand[8];
    r = $urandom_range(0, 99);
    if (r < 1) begin
      s.rst = 1;
    end else if (r < 4) begin
      s.start = 1;
      if ($urandom_range(0, 9) == 0) begin
        s.sx = $urandom_range(0, 7); s.sy = $urandom_range(0, 7);
      end else begin
        s.sx = $urandom_range(0, BW[b] - 1); s.sy = $urandom_range(0, BH[b] - 1);
      end
      s.vld = 1'($urandom_range(0, 1)); s.undo = 1'($urandom_range(0, 1));
    end else if (r < 18) begin
      s.undo = 1; s.vld = 1'($urandom_range(0, 1)); s.mv = $urandom_range(0, 7);
    end else if (r < 90) begin
      s.vld = 1;
      n = 0;
      for (int m = 0; m < 8; m++) if (is_legal(b, m)) begin cand[n] = m; n++; end
      if (n > 0 && $urandom_range(0, 99) < 85) s.mv = cand[$urandom_range(0, n - 1)];
      else s.mv = $urandom_range(0, 7);
    end
    return s;
  endfunction

  task automatic step(input stim_t a, input stim_t b);
    exp_t ea, eb;
    rst_a = a.rst; ifa.start = a.start; ifa.start_x = 3'(a.sx); ifa.start_y = 3'(a.sy);
    ifa.move_vld = a.vld; ifa.move = 3'(a.mv); ifa.undo = a.undo;
    rst_b = b.rst; ifb.start = b.start; ifb.start_x = 3'(b.sx); ifb.start_y = 2'(b.sy);
    ifb.move_vld = b.vld; ifb.move = 3'(b.mv); ifb.undo = b.undo;
    model_step(0, a, ea);
    model_step(1, b, eb);
    qa.push_back(ea);
    qb.push_back(eb);
    @(posedge clk);
    #2;
  endtask

  task automatic run_a(input stim_t s); step(s, idle()); endtask
  task automatic run_b(input stim_t s); step(idle(), s); endtask

  // Depth-first search for an open 5x5 tour from (0,0).
  task automatic build_tour(output bit ok);
    bit vis[25];
    int nxt[25];
    int x, y, d, m, tx, ty;
    bit found;
    for (int i = 0; i < 25; i++) begin vis[i] = 1'b0; nxt[i] = 0; end
    vis[0] = 1'b1; x = 0; y = 0; d = 0; tx = 0; ty = 0;
    while (d >= 0 && d < 24) begin
      found = 1'b0;
      m = nxt[d];
      while (m < 8 && !found) begin
        tx = x + DX[m]; ty = y + DY[m];
        if (tx >= 0 && tx < 5 && ty >= 0 && ty < 5 && !vis[ty * 5 + tx]) found = 1'b1;
        else m++;
      end
      if (found) begin
        nxt[d] = m + 1; tour[d] = m;
        x = tx; y = ty; vis[y * 5 + x] = 1'b1;
        d++;
        if (d < 24) nxt[d] = 0;
      end else begin
        d--;
        if (d >= 0) begin
          vis[y * 5 + x] = 1'b0;
          x -= DX[tour[d]]; y -= DY[tour[d]];
        end
      end
    end
    ok = (d == 24);
  endtask

  task automatic check_out(input string p, input exp_t e, input int x, input int y,
                           input int cnt, input int dn, input int er, input int cd);
    chk({p, "cur_x"}, x, int'(e.x));
    chk({p, "cur_y"}, y, int'(e.y));
    chk({p, "visited_cnt"}, cnt, int'(e.cnt));
    chk({p, "done"}, dn, int'(e.done));
    chk({p, "err"}, er, int'(e.err));
    chk({p, "err_code"}, cd, int'(e.code));
  endtask

  // Monitor: move_rdy is checked mid-cycle against the inputs being offered,
  // registered status just after the edge that consumes them.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        chk("a_move_rdy", int'(ifa.move_rdy), int'(qa[0].rdy));
        chk("b_move_rdy", int'(ifb.move_rdy), int'(qb[0].rdy));
      end
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check_out("a_", e, int'(ifa.cur_x), int'(ifa.cur_y), int'(ifa.visited_cnt),
                  int'(ifa.done), int'(ifa.err), int'(ifa.err_code));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check_out("b_", e, int'(ifb.cur_x), int'(ifb.cur_y), int'(ifb.visited_cnt),
                  int'(ifb.done), int'(ifb.err), int'(ifb.err_code));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1);
  end

  initial begin
    bit    ok;
    stim_t s;
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.start = 0; ifa.start_x = '0; ifa.start_y = '0; ifa.move_vld = 0; ifa.move = '0; ifa.undo = 0;
    ifb.start = 0; ifb.start_x = '0; ifb.start_y = '0; ifb.move_vld = 0; ifb.move = '0; ifb.undo = 0;
    @(posedge clk);
    #2;
    step(mk_rst(), mk_rst());
    step(mk_rst(), mk_rst());
    step(idle(), idle());

    build_tour(ok);
    chk("tour_search_found", int'(ok), 1);

    // Full legal tour, one move per cycle, then undo out of DONE and re-complete.
    run_a(mk_start(0, 0));
    for (int i = 0; i < 24; i++) run_a(mk_move(tour[i]));
    run_a(idle());
    run_a(mk_move(0));
    run_a(mk_undo());
    run_a(mk_move(tour[23]));
    run_a(idle());

    // Off-board first move; further moves refused.
    run_a(mk_start(0, 0));
    run_a(mk_move(3));
    run_a(mk_move(0));
    run_a(idle());

    // Revisit.
    run_a(mk_start(0, 0));
    run_a(mk_move(0));
    run_a(mk_move(4));
    run_a(idle());

    // Undo, undo on empty stack, restart clears the error.
    run_a(mk_start(0, 0));
    run_a(mk_move(0));
    run_a(mk_undo());
    run_a(mk_undo());
    run_a(idle());
    run_a(mk_start(2, 2));
    run_a(idle());

    // 6x4 board from the far corner.
    run_b(mk_start(5, 3));
    run_b(mk_move(7));
    run_b(idle());
    run_b(mk_start(5, 3));
    run_b(mk_move(3));
    run_b(idle());
    s = mk_start(0, 0); s.vld = 1; s.mv = 0; s.undo = 1;
    run_b(s);
    run_b(idle());

    // Reset mid-tour; moves ignored until the next start.
    run_a(mk_start(0, 0));
    for (int i = 0; i < 7; i++) run_a(mk_move(tour[i]));
    run_a(mk_rst());
    run_a(mk_move(tour[0]));
    run_a(mk_move(tour[0]));
    run_a(mk_undo());

    // Out-of-range start coordinates.
    run_a(mk_start(5, 0));
    run_a(idle());
    run_a(mk_start(0, 5));
    run_a(idle());

    for (int i = 0; i < 3000; i++) step(rand_stim(0), rand_stim(1));
    step(idle(), idle());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tour_monitor.md
# tour_monitor

Parametrised knight's-tour tracker and rule checker for a BOARD_W × BOARD_H board. It sits beside the tour-logic block in KnightsTour and consumes the stream of move indices that tour logic issues, including its backtracking undos. It holds current position, a visited-square map and a LIFO of accepted moves, and flags illegal moves. It asserts `done` when every square has been visited, replacing per-square board inspection from the bench and generalising the fixed 5×5 check.

## Interface
Parameters:
- BOARD_W, 5, board width in squares (≥3).
- BOARD_H, 5, board height in squares (≥3).
- Derived localparams:
  - XW = $clog2(BOARD_W)
  - YW = $clog2(BOARD_H)
  - NSQ = BOARD_W*BOARD_H
  - CW = $clog2(NSQ+1)

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; (re)initialise the tour at (start_x, start_y).
- start_x  in  XW  starting column; start_y  in  YW  starting row.
- move_vld  in  1  move offered.
- move  in  3  move index, offsets from tour_pkg.
- move_rdy  out  1  move accepted this cycle when move_vld && move_rdy.
- undo  in  1  pulse; pop the last accepted move.
- cur_x  out  XW, cur_y  out  YW  current knight square.
- visited_cnt  out  CW  squares visited, including the start square.
- done  out  1  visited_cnt == NSQ.
- err  out  1  sticky error.
- err_code  out  2  00 none, 01 off-board, 10 revisit, 11 undo on empty stack.

## Operation
- Move offsets (dx,dy):
  - 0:(+1,+2), 1:(−1,+2), 2:(−2,+1), 3:(−2,−1)
  - 4:(−1,−2), 5:(+1,−2), 6:(+2,−1), 7:(+2,+1)
  - Inverse of index m is m^4.
- Target arithmetic is signed at XW+2 / YW+2 bits. Off-board means the target is <0 or ≥BOARD_W (resp. BOARD_H).
- States: IDLE, TRACK, DONE, ERR.
- IDLE:
  - Ignores move and undo.
  - start → TRACK: board cleared, start square marked, cur = start, visited_cnt = 1, stack emptied.
  - Out-of-range start_x/start_y → ERR with code 01.
- TRACK, accepted move:
  - Off-board target → ERR, code 01. Position, board and count unchanged.
  - Visited target → ERR, code 10. Position, board and count unchanged.
  - Otherwise: mark target, cur = target, visited_cnt+1, push move.
  - If the new count == NSQ → DONE.
- Undo in TRACK or DONE:
  - Stack non-empty: clear the current square's bit, step by the inverse of the popped move, visited_cnt−1. DONE → TRACK.
  - Stack empty → ERR, code 11.
- ERR: only start or rst leaves. err and err_code hold until then.
- move_rdy = (state==TRACK) && !undo && !start.
- Priority within a cycle: rst > start > undo > move.
- start is honoured in every state, including mid-tour and ERR, and fully reinitialises. err clears on start.
- Stack depth is NSQ−1. Overflow cannot occur without a revisit, which is caught first.

## Timing
- All outputs registered except move_rdy, which is combinational from state, undo and start.
- Move, undo and start take effect on the next clock edge. cur, visited_cnt, done and err update one cycle after acceptance.
- done rises in the cycle after the accepting edge of the NSQ−1th move. It falls the cycle after an undo or start.
- Reset values: state IDLE, cur_x/cur_y 0, visited_cnt 0, done 0, err 0, err_code 00, move_rdy 0, board all 0, stack pointer 0.
- rst mid-tour discards all state on that edge. No partial updates.
- Back-to-back moves are sustained at one per cycle.

## Structure
- tour_pkg holds:
  - the move-offset constant arrays (dx/dy as signed 3-bit)
  - the state enum
  - the err_code enum
  - an inverse-move function
- Sub-module tour_stack: parametrised LIFO (DEPTH, WIDTH=3) with push, pop, clear, empty and top outputs. The board map is a flat NSQ-bit register inside tour_monitor.

## Test plan
- 5×5, start (0,0), feed a precomputed legal 24-move tour at one move per cycle → move_rdy high throughout, visited_cnt 25, done=1 one cycle after the 24th accept, err=0.
- 5×5, start (0,0), move 3 → err=1, err_code=01, cur (0,0), visited_cnt 1. A further move is not accepted (move_rdy=0).
- 5×5, start (0,0), move 0 → (1,2), then move 4 → err_code=10, cur (1,2), visited_cnt 2.
- 5×5, start (0,0), move 0 then undo → cur (0,0), visited_cnt 1, square (1,2) cleared. A second undo → err_code=11. A subsequent start at (2,2) → err=0, TRACK, cnt 1.
- BOARD_W=6, BOARD_H=4, start (5,3):
  - move 7 → err_code=01.
  - Restart at (5,3), move 3 → cur (3,2), cnt 2.
  - Same cycle move_vld+undo+start → start wins.
- 5×5, seven moves accepted, then rst → next cycle all outputs at reset values. Moves are ignored until start.
